// File: rtl/ariane_pkg.sv
// Shared types for the scoreboard commit path: functional units, ops, exception
// and scoreboard entry structs, plus the commit FSM state enum.
package ariane_pkg;

  localparam int NR_COMMIT_PORTS = 2;

  typedef enum logic [2:0] {
    NONE,
    LOAD,
    STORE,
    ALU,
    CTRL_FLOW,
    MULT,
    CSR
  } fu_t;

  typedef enum logic [3:0] {
    ADD,
    SUB,
    LD,
    SD,
    MUL,
    CSR_RW,
    BEQ,
    AMO_LRD,
    AMO_SCD,
    AMO_SWAPD,
    AMO_ADDD
  } fu_op;

  typedef struct packed {
    logic [63:0] cause;
    logic [63:0] tval;
    logic        valid;
  } exception_t;

  typedef struct packed {
    fu_t         fu;
    fu_op        op;
    logic [4:0]  rd;
    logic [63:0] result;
    exception_t  ex;
    logic        valid;
  } scoreboard_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    AMO_REQ,
    AMO_WAIT
  } commit_state_t;

  function automatic logic is_amo(fu_op op);
    return (op == AMO_LRD) || (op == AMO_SCD) || (op == AMO_SWAPD) || (op == AMO_ADDD);
  endfunction

endpackage

// File: rtl/commit_retire.sv
// Retires up to two in-order scoreboard heads per cycle and sequences atomics.
// Optional retire counter enabled by defining COMMIT_INSTRET_EN.
//
// state    | meaning
// IDLE     | normal retirement on both ports
// AMO_REQ  | one-cycle AMO start pulse to the LSU
// AMO_WAIT | waiting for AMO completion, port 0 head held
module commit_retire
  import ariane_pkg::*;
(
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  halt_i,
  input  logic                                  flush_i,
  input  scoreboard_entry_t                     commit_instr_i [NR_COMMIT_PORTS],
  output logic [NR_COMMIT_PORTS-1:0]            commit_ack_o,
  output logic [NR_COMMIT_PORTS-1:0][4:0]       waddr_o,
  output logic [NR_COMMIT_PORTS-1:0][63:0]      wdata_o,
  output logic [NR_COMMIT_PORTS-1:0]            we_o,
  output logic                                  commit_lsu_o,
  input  logic                                  commit_lsu_ready_i,
  output logic                                  amo_commit_o,
  input  logic                                  amo_valid_commit_i,
  input  logic [63:0]                           amo_result_i,
  output exception_t                            exception_o,
  output logic [63:0]                           instret_o
);

  commit_state_t state_q, state_d;
  exception_t    exception_q, exception_d;
  logic          p0_simple;
  logic          unused_op1;

  assign unused_op1 = ^commit_instr_i[1].op;

  function automatic logic is_simple_fu(fu_t fu);
    return (fu == ALU) || (fu == CTRL_FLOW) || (fu == MULT);
  endfunction

  always_comb begin
    state_d      = state_q;
    exception_d  = '0;
    commit_ack_o = '0;
    we_o         = '0;
    commit_lsu_o = 1'b0;
    p0_simple    = 1'b0;
    waddr_o[0]   = commit_instr_i[0].rd;
    waddr_o[1]   = commit_instr_i[1].rd;
    wdata_o[0]   = commit_instr_i[0].result;
    wdata_o[1]   = commit_instr_i[1].result;

    case (state_q)
      IDLE: begin
        if (commit_instr_i[0].valid && !halt_i && !flush_i) begin
          if (commit_instr_i[0].ex.valid) begin
            commit_ack_o[0] = 1'b1;
            exception_d     = commit_instr_i[0].ex;
          end else if (is_amo(commit_instr_i[0].op)) begin
            state_d = AMO_REQ;
          end else begin
            case (commit_instr_i[0].fu)
              ALU, CTRL_FLOW, MULT: begin
                commit_ack_o[0] = 1'b1;
                we_o[0]         = (commit_instr_i[0].rd != 5'd0);
                p0_simple       = 1'b1;
              end
              CSR, LOAD: begin
                commit_ack_o[0] = 1'b1;
                we_o[0]         = (commit_instr_i[0].rd != 5'd0);
              end
              STORE: begin
                commit_lsu_o    = 1'b1;
                commit_ack_o[0] = commit_lsu_ready_i;
              end
              default: ;
            endcase
          end
        end
      end
      AMO_REQ: state_d = AMO_WAIT;
      // Flush is deliberately ignored here: the memory side effect is in flight.
      AMO_WAIT: begin
        if (amo_valid_commit_i) begin
          commit_ack_o[0] = 1'b1;
          we_o[0]         = (commit_instr_i[0].rd != 5'd0);
          wdata_o[0]      = amo_result_i;
          state_d         = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (p0_simple && commit_instr_i[1].valid && !commit_instr_i[1].ex.valid &&
        is_simple_fu(commit_instr_i[1].fu)) begin
      commit_ack_o[1] = 1'b1;
      we_o[1]         = (commit_instr_i[1].rd != 5'd0);
    end
  end

  assign amo_commit_o = (state_q == AMO_REQ);
  assign exception_o  = exception_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      exception_q <= '0;
    end else begin
      state_q     <= state_d;
      exception_q <= exception_d;
    end
  end

`ifdef COMMIT_INSTRET_EN
  logic [63:0] instret_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      instret_q <= '0;
    end else begin
      instret_q <= instret_q + 64'(commit_ack_o[0]) + 64'(commit_ack_o[1]);
    end
  end

  assign instret_o = instret_q;
`else
  assign instret_o = '0;
`endif

endmodule

// File: tb/tb_commit_retire.sv
// Directed bench for commit_retire: dual retire, store handshake, AMO sequence,
// exceptions, halt/flush and reset during an AMO.
module tb_commit_retire;
  import ariane_pkg::*;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              halt_i, flush_i;
  scoreboard_entry_t commit_instr_i [NR_COMMIT_PORTS];
  logic [1:0]        commit_ack_o;
  logic [1:0][4:0]   waddr_o;
  logic [1:0][63:0]  wdata_o;
  logic [1:0]        we_o;
  logic              commit_lsu_o, commit_lsu_ready_i;
  logic              amo_commit_o, amo_valid_commit_i;
  logic [63:0]       amo_result_i;
  exception_t        exception_o;
  logic [63:0]       instret_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] exp_ret = 0;

  commit_retire dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .halt_i(halt_i), .flush_i(flush_i),
    .commit_instr_i(commit_instr_i), .commit_ack_o(commit_ack_o),
    .waddr_o(waddr_o), .wdata_o(wdata_o), .we_o(we_o),
    .commit_lsu_o(commit_lsu_o), .commit_lsu_ready_i(commit_lsu_ready_i),
    .amo_commit_o(amo_commit_o), .amo_valid_commit_i(amo_valid_commit_i),
    .amo_result_i(amo_result_i), .exception_o(exception_o), .instret_o(instret_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_instret(input string tag);
`ifdef COMMIT_INSTRET_EN
    check(tag, instret_o, exp_ret);
`else
    check(tag, instret_o, 64'd0);
`endif
  endtask

  function automatic scoreboard_entry_t mk(input logic v, input fu_t fu, input fu_op op,
                                           input logic [4:0] rd, input logic [63:0] res);
    scoreboard_entry_t e;
    e        = '0;
    e.valid  = v;
    e.fu     = fu;
    e.op     = op;
    e.rd     = rd;
    e.result = res;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_heads();
    commit_instr_i[0] = '0;
    commit_instr_i[1] = '0;
  endtask

  initial begin
    rst_ni = 1'b0;
    halt_i = 1'b0; flush_i = 1'b0;
    commit_lsu_ready_i = 1'b0; amo_valid_commit_i = 1'b0; amo_result_i = '0;
    clear_heads();
    #3;
    check("rst_ack", 64'(commit_ack_o), 0);
    check("rst_we", 64'(we_o), 0);
    check("rst_lsu", 64'(commit_lsu_o), 0);
    check("rst_amo", 64'(amo_commit_o), 0);
    check("rst_exv", 64'(exception_o.valid), 0);
    check("rst_excause", exception_o.cause, 0);
    check_instret("rst_instret");
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();

    // Dual retire: ALU on port 0, MULT on port 1
    commit_instr_i[0] = mk(1, ALU, ADD, 5'd5, 64'hDEAD);
    commit_instr_i[1] = mk(1, MULT, MUL, 5'd6, 64'hBEEF);
    settle();
    check("dual_ack", 64'(commit_ack_o), 64'b11);
    check("dual_we", 64'(we_o), 64'b11);
    check("dual_waddr", 64'(waddr_o), {54'd0, 5'd6, 5'd5});
    check("dual_wdata0", wdata_o[0], 64'hDEAD);
    check("dual_wdata1", wdata_o[1], 64'hBEEF);
    tick();
    exp_ret = 2;
    clear_heads();
    settle();
    check_instret("dual_instret");

    // Store waits three cycles for the store buffer
    commit_instr_i[0] = mk(1, STORE, SD, 5'd0, 64'h0);
    commit_instr_i[1] = mk(1, ALU, ADD, 5'd9, 64'h9);
    for (int i = 0; i < 3; i++) begin
      settle();
      check("st_lsu_wait", 64'(commit_lsu_o), 1);
      check("st_ack_wait", 64'(commit_ack_o), 0);
      tick();
    end
    commit_lsu_ready_i = 1'b1;
    settle();
    check("st_lsu_go", 64'(commit_lsu_o), 1);
    check("st_ack_go", 64'(commit_ack_o), 64'b01);
    check("st_we", 64'(we_o), 0);
    tick();
    exp_ret = 3;
    commit_lsu_ready_i = 1'b0;
    clear_heads();
    settle();
    check_instret("st_instret");

    // AMO: pulse next cycle, response 5 cycles after the pulse, flush ignored
    commit_instr_i[0] = mk(1, STORE, AMO_ADDD, 5'd7, 64'h0);
    commit_instr_i[1] = mk(1, ALU, ADD, 5'd8, 64'h8);
    settle();
    check("amo_n_ack", 64'(commit_ack_o), 0);
    check("amo_n_pulse", 64'(amo_commit_o), 0);
    tick();
    check("amo_pulse", 64'(amo_commit_o), 1);
    check("amo_pulse_ack", 64'(commit_ack_o), 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      flush_i = (i == 1);
      settle();
      check("amo_wait_pulse", 64'(amo_commit_o), 0);
      check("amo_wait_ack", 64'(commit_ack_o), 0);
      tick();
    end
    flush_i = 1'b0;
    amo_valid_commit_i = 1'b1;
    amo_result_i = 64'h42;
    settle();
    check("amo_resp_ack", 64'(commit_ack_o), 64'b01);
    check("amo_resp_we", 64'(we_o), 64'b01);
    check("amo_resp_waddr", 64'(waddr_o[0]), 7);
    check("amo_resp_wdata", wdata_o[0], 64'h42);
    tick();
    exp_ret = 4;
    amo_valid_commit_i = 1'b0;
    clear_heads();
    settle();
    check("amo_after_pulse", 64'(amo_commit_o), 0);
    check_instret("amo_instret");

    // Exception retire, reported the next cycle only
    commit_instr_i[0] = mk(1, ALU, ADD, 5'd3, 64'h33);
    commit_instr_i[0].ex.valid = 1'b1;
    commit_instr_i[0].ex.cause = 64'd2;
    commit_instr_i[1] = mk(1, ALU, ADD, 5'd4, 64'h44);
    settle();
    check("exc_ack", 64'(commit_ack_o), 64'b01);
    check("exc_we", 64'(we_o), 0);
    check("exc_not_yet", 64'(exception_o.valid), 0);
    tick();
    exp_ret = 5;
    clear_heads();
    settle();
    check("exc_valid", 64'(exception_o.valid), 1);
    check("exc_cause", exception_o.cause, 64'd2);
    tick();
    check("exc_gone", 64'(exception_o.valid), 0);
    check_instret("exc_instret");

    // Halt and flush suppress retirement; rd=0 retires without a write
    commit_instr_i[0] = mk(1, ALU, ADD, 5'd10, 64'hA);
    commit_instr_i[1] = mk(1, ALU, SUB, 5'd11, 64'hB);
    halt_i = 1'b1;
    settle();
    check("halt_ack", 64'(commit_ack_o), 0);
    check("halt_we", 64'(we_o), 0);
    halt_i = 1'b0;
    flush_i = 1'b1;
    commit_instr_i[0] = mk(1, STORE, SD, 5'd0, 64'h0);
    settle();
    check("flush_ack", 64'(commit_ack_o), 0);
    check("flush_lsu", 64'(commit_lsu_o), 0);
    tick();
    flush_i = 1'b0;
    commit_instr_i[0] = mk(1, ALU, ADD, 5'd0, 64'h77);
    commit_instr_i[1] = '0;
    settle();
    check("rd0_ack", 64'(commit_ack_o), 64'b01);
    check("rd0_we", 64'(we_o), 0);
    tick();
    exp_ret = 6;
    // Port 1 blocked when it is not a simple unit, or port 0 is a CSR
    commit_instr_i[0] = mk(1, ALU, ADD, 5'd1, 64'h1);
    commit_instr_i[1] = mk(1, CSR, CSR_RW, 5'd2, 64'h2);
    settle();
    check("p1_csr_ack", 64'(commit_ack_o), 64'b01);
    tick();
    commit_instr_i[0] = mk(1, CSR, CSR_RW, 5'd1, 64'h1);
    commit_instr_i[1] = mk(1, ALU, ADD, 5'd2, 64'h2);
    settle();
    check("p0_csr_ack", 64'(commit_ack_o), 64'b01);
    tick();
    exp_ret = 8;
    clear_heads();
    settle();
    check_instret("misc_instret");

    // Reset while waiting on an AMO
    commit_instr_i[0] = mk(1, STORE, AMO_SWAPD, 5'd12, 64'h0);
    tick();
    tick();
    rst_ni = 1'b0;
    settle();
    exp_ret = 0;
    check("rstamo_ack", 64'(commit_ack_o), 0);
    check("rstamo_pulse", 64'(amo_commit_o), 0);
    check("rstamo_exv", 64'(exception_o.valid), 0);
    check_instret("rstamo_instret");
    amo_valid_commit_i = 1'b1;
    amo_result_i = 64'h99;
    settle();
    check("rstamo_idle_ack", 64'(commit_ack_o), 0);
    check("rstamo_idle_we", 64'(we_o), 0);
    amo_valid_commit_i = 1'b0;
    clear_heads();
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();
    check("post_rst_pulse", 64'(amo_commit_o), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
